jtframe_sdram_arbn: RTL and testbench
=====================================

JTFRAME_SDRAM_ARBN -- requirements
Module: jtframe_sdram_arbn

Interface
REQ-001 SHALL have parameter SLOTS, default 5, meaning number of request channels, legal 2..8.
REQ-002 SHALL have parameter SDRAMW, default 22, meaning SDRAM word-address width.
REQ-003 SHALL have parameter RR, default 0, meaning 0 = fixed priority (slot 0 highest), 1 = round-robin.
REQ-004 SHALL have parameter WREN, default 5'b00011 (SLOTS bits), meaning per-slot write permission.
REQ-005 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-007 SHALL have port req, input, SLOTS, per-slot request pending.
REQ-008 SHALL have port req_rnw, input, SLOTS, per-slot 1 = read, 0 = write.
REQ-009 SHALL have port req_addr, input, SLOTS*SDRAMW, packed addresses; slot n at [n*SDRAMW +: SDRAMW].
REQ-010 SHALL have port req_din, input, SLOTS*16, packed write data; slot n at [n*16 +: 16].
REQ-011 SHALL have port req_wrmask, input, SLOTS*2, packed byte masks, active low.
REQ-012 SHALL have port slot_sel, output, SLOTS, one-hot grant; held for the whole transaction.
REQ-013 SHALL have port sdram_ack, input, 1, controller accepted the command.
REQ-014 SHALL have ports sdram_rd and sdram_wr, output, 1 each, command strobes.
REQ-015 SHALL have port sdram_addr, output, SDRAMW, command address.
REQ-016 SHALL have port data_write, output, 16, write data.
REQ-017 SHALL have port sdram_wrmask, output, 2, byte mask, active low.
REQ-018 SHALL have port data_rdy, input, 1, transaction complete (read data valid or write done).
REQ-019 SHALL have port busy, output, 1, high while slot_sel is non-zero.

Function
REQ-020 SHALL compute active = req & ~slot_sel; only active slots are eligible for a grant.
REQ-021 SHALL evaluate a grant when slot_sel is zero or data_rdy is high (back-to-back, zero idle cycles).
REQ-022 SHALL, at a grant evaluation, clear slot_sel and, if any slot is active, set exactly one slot_sel bit, registered one cycle after evaluation.
REQ-023 SHALL with RR=0 grant the lowest-index active slot.
REQ-024 SHALL with RR=1 grant the first active slot searching upward, with wrap, from the index after the last granted slot; the last-granted pointer resets to SLOTS-1.
REQ-025 SHALL on grant load sdram_addr from the winner's req_addr.
REQ-026 SHALL on grant of a read (req_rnw=1, or WREN bit 0) assert sdram_rd=1, sdram_wr=0, sdram_wrmask=2'b11.
REQ-027 SHALL on grant of a write (req_rnw=0 and WREN bit 1) assert sdram_wr=1, sdram_rd=0, load data_write and sdram_wrmask from the slot.
REQ-028 SHALL treat a write request from a slot with WREN bit 0 as a read.
REQ-029 SHALL hold sdram_rd/sdram_wr until the cycle after sdram_ack, then drive them low.
REQ-030 SHALL, when sdram_ack and a new grant coincide, let the new grant's strobes win.
REQ-031 SHALL, when data_rdy arrives with no active slot, return slot_sel to zero and leave strobes low.
REQ-032 SHALL ignore data_rdy while slot_sel is zero (no state change).
REQ-033 SHALL keep sdram_addr, data_write and sdram_wrmask stable between grants.
REQ-034 SHALL not re-grant the current slot in the same evaluation in which its data_rdy arrives (RR=1) unless it is the only active slot.

Reset
REQ-035 SHALL on rst force slot_sel=0, sdram_rd=0, sdram_wr=0, sdram_addr=0, data_write=0, sdram_wrmask=2'b11, busy=0, RR pointer=SLOTS-1.
REQ-036 SHALL abandon any in-flight transaction on rst; a later data_rdy is ignored per REQ-032.

Verification
REQ-037 SHALL verify fixed priority: RR=0, req=5'b10100 held -> slot_sel=5'b00100, sdram_rd=1, sdram_addr=slot 2 address; after data_rdy -> slot_sel=5'b10000.
REQ-038 SHALL verify round-robin: RR=1, req=5'b00111 held, data_rdy every 4 cycles -> grant order 0,1,2,0,1,2.
REQ-039 SHALL verify writes: slot 1 req_rnw=0, din=16'hA55A, wrmask=2'b01 -> sdram_wr=1, data_write=16'hA55A, sdram_wrmask=2'b01; slot 3 write -> sdram_rd=1, sdram_wrmask=2'b11.
REQ-040 SHALL verify strobe handshake: sdram_ack delayed 3 cycles -> sdram_rd high exactly until cycle after ack; ack coinciding with data_rdy and pending req -> strobe stays high for the new grant.
REQ-041 SHALL verify reset mid-transaction: rst during slot 4 read -> all outputs at reset values next cycle; stray data_rdy afterwards -> slot_sel stays 0.
REQ-042 SHALL verify SLOTS=8, SDRAMW=23 build: slot 7 address 23'h7FFFFF granted -> sdram_addr=23'h7FFFFF.

Source files
------------

// File: rtl/jtframe_sdram_arbn.sv
// SDRAM request arbiter: picks one of SLOTS request channels, holds the grant
// for the whole transaction and issues the read/write strobe to the controller.
//
// Handshake: a slot signals a pending request on req[n]. The grant appears on
// slot_sel one cycle after it is evaluated and stays put until data_rdy. The
// strobe (sdram_rd/sdram_wr) stays high through the cycle where sdram_ack is
// seen and drops on the next edge. Address, data and mask only change at a
// new grant.
module jtframe_sdram_arbn #(
  parameter int SLOTS  = 5,
  parameter int SDRAMW = 22,
  parameter int RR     = 0,
  parameter logic [SLOTS-1:0] WREN = {{(SLOTS-2){1'b0}}, 2'b11}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SLOTS-1:0]         req,
  input  logic [SLOTS-1:0]         req_rnw,
  input  logic [SLOTS*SDRAMW-1:0]  req_addr,
  input  logic [SLOTS*16-1:0]      req_din,
  input  logic [SLOTS*2-1:0]       req_wrmask,
  output logic [SLOTS-1:0]         slot_sel,
  input  logic                     sdram_ack,
  output logic                     sdram_rd,
  output logic                     sdram_wr,
  output logic [SDRAMW-1:0]        sdram_addr,
  output logic [15:0]              data_write,
  output logic [1:0]               sdram_wrmask,
  input  logic                     data_rdy,
  output logic                     busy
);

  localparam int IW = $clog2(SLOTS);
  localparam logic [IW-1:0] LAST_RST = IW'(SLOTS-1);

  logic [SLOTS-1:0] active;
  logic             eval;
  logic             win_found;
  logic             win_write;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    cand_idx;
  logic [IW-1:0]    last_ptr;

  // The slot currently being served is never eligible, so a finishing slot
  // cannot immediately win again while it still holds req high.
  assign active    = req & ~slot_sel;
  assign busy      = |slot_sel;
  assign eval      = ~busy | data_rdy;
  assign win_write = ~req_rnw[win_idx] & WREN[win_idx];

  // Winner search: lowest index for fixed priority, or upward from the slot
  // after the last grant (wrapping) for round-robin.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (RR != 0) cand_idx = IW'((int'(last_ptr) + 1 + i) % SLOTS);
      else         cand_idx = IW'(i);
      if (!win_found && active[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Grant, command register and strobe handshake. A new grant takes
  // precedence over a coincident ack so back-to-back commands keep the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_sel     <= '0;
      sdram_rd     <= 1'b0;
      sdram_wr     <= 1'b0;
      sdram_addr   <= '0;
      data_write   <= '0;
      sdram_wrmask <= 2'b11;
      last_ptr     <= LAST_RST;
    end else if (eval && win_found) begin
      slot_sel   <= {{(SLOTS-1){1'b0}}, 1'b1} << win_idx;
      last_ptr   <= win_idx;
      sdram_addr <= req_addr[int'(win_idx)*SDRAMW +: SDRAMW];
      if (win_write) begin
        sdram_wr     <= 1'b1;
        sdram_rd     <= 1'b0;
        data_write   <= req_din[int'(win_idx)*16 +: 16];
        sdram_wrmask <= req_wrmask[int'(win_idx)*2 +: 2];
      end else begin
        sdram_rd     <= 1'b1;
        sdram_wr     <= 1'b0;
        sdram_wrmask <= 2'b11;
      end
    end else if (data_rdy && busy) begin
      slot_sel <= '0;
      sdram_rd <= 1'b0;
      sdram_wr <= 1'b0;
    end else if (sdram_ack) begin
      sdram_rd <= 1'b0;
      sdram_wr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtframe_sdram_arbn.sv
// Bench for jtframe_sdram_arbn: directed scenarios plus a randomized run
// checked against an integer-level arbitration model for both priority modes.
module tb_jtframe_sdram_arbn;

  localparam logic [4:0] WREN5 = 5'b00011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus for the two 5-slot instances
  logic [4:0]    req = '0, req_rnw = '1;
  logic [109:0]  req_addr = '0;
  logic [79:0]   req_din = '0;
  logic [9:0]    req_wrmask = '1;
  logic          sdram_ack = 1'b0, data_rdy = 1'b0;

  logic [4:0]  ss0, ss1;
  logic        rd0, wr0, busy0, rd1, wr1, busy1;
  logic [21:0] addr0, addr1;
  logic [15:0] dw0, dw1;
  logic [1:0]  mk0, mk1;

  // 8-slot instance
  logic [7:0]    req8 = '0, rnw8 = '1;
  logic [183:0]  addr8_in = '0;
  logic [127:0]  din8 = '0;
  logic [15:0]   mask8 = '1;
  logic          ack8 = 1'b0, rdy8 = 1'b0;
  logic [7:0]    ss2;
  logic          rd2, wr2, busy2;
  logic [22:0]   addr2;
  logic [15:0]   dw2;
  logic [1:0]    mk2;

  jtframe_sdram_arbn #(.RR(0)) dut_fixed (
    .clk(clk), .rst(rst), .req(req), .req_rnw(req_rnw), .req_addr(req_addr),
    .req_din(req_din), .req_wrmask(req_wrmask), .slot_sel(ss0),
    .sdram_ack(sdram_ack), .sdram_rd(rd0), .sdram_wr(wr0), .sdram_addr(addr0),
    .data_write(dw0), .sdram_wrmask(mk0), .data_rdy(data_rdy), .busy(busy0));

  jtframe_sdram_arbn #(.RR(1)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .req_rnw(req_rnw), .req_addr(req_addr),
    .req_din(req_din), .req_wrmask(req_wrmask), .slot_sel(ss1),
    .sdram_ack(sdram_ack), .sdram_rd(rd1), .sdram_wr(wr1), .sdram_addr(addr1),
    .data_write(dw1), .sdram_wrmask(mk1), .data_rdy(data_rdy), .busy(busy1));

  jtframe_sdram_arbn #(.SLOTS(8), .SDRAMW(23), .RR(0), .WREN(8'h03)) dut_wide (
    .clk(clk), .rst(rst), .req(req8), .req_rnw(rnw8), .req_addr(addr8_in),
    .req_din(din8), .req_wrmask(mask8), .slot_sel(ss2),
    .sdram_ack(ack8), .sdram_rd(rd2), .sdram_wr(wr2), .sdram_addr(addr2),
    .data_write(dw2), .sdram_wrmask(mk2), .data_rdy(rdy8), .busy(busy2));

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model (index 0 fixed, 1 round-robin) -------
  int          m_cur[2];   // granted slot, -1 when idle
  int          m_last[2];  // last granted slot
  bit          m_rd[2], m_wr[2];
  logic [21:0] m_addr[2];
  logic [15:0] m_dw[2];
  logic [1:0]  m_mk[2];

  task automatic model_step(input int c);
    int win;
    int s;
    bit is_wr;
    if (rst) begin
      m_cur[c] = -1; m_last[c] = 4; m_rd[c] = 0; m_wr[c] = 0;
      m_addr[c] = '0; m_dw[c] = '0; m_mk[c] = 2'b11;
    end else if (m_cur[c] < 0 || data_rdy) begin
      win = -1;
      for (int k = 0; k < 5; k++) begin
        s = (c == 1) ? (m_last[c] + 1 + k) % 5 : k;
        if (win < 0 && req[s] && s != m_cur[c]) win = s;
      end
      if (win >= 0) begin
        is_wr     = !req_rnw[win] && WREN5[win];
        m_cur[c]  = win;
        m_last[c] = win;
        m_addr[c] = req_addr[win*22 +: 22];
        m_rd[c]   = !is_wr;
        m_wr[c]   = is_wr;
        if (is_wr) begin
          m_dw[c] = req_din[win*16 +: 16];
          m_mk[c] = req_wrmask[win*2 +: 2];
        end else begin
          m_mk[c] = 2'b11;
        end
      end else if (m_cur[c] >= 0) begin
        m_cur[c] = -1; m_rd[c] = 0; m_wr[c] = 0;
      end
    end else if (sdram_ack) begin
      m_rd[c] = 0; m_wr[c] = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; req_rnw = '1; sdram_ack = 0; data_rdy = 0;
    req_wrmask = '1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({ss0, rd0, wr0, addr0, dw0, mk0, busy0} !== {5'b0, 1'b0, 1'b0, 22'h0, 16'h0, 2'b11, 1'b0}) begin
      n_err++;
      $display("FAIL reset_fixed: got ss=%b rd=%b wr=%b addr=%h dw=%h mk=%b busy=%b, want all reset values",
               ss0, rd0, wr0, addr0, dw0, mk0, busy0);
    end
    n_vec++;
    if ({ss1, rd1, wr1, mk1, busy1} !== {5'b0, 1'b0, 1'b0, 2'b11, 1'b0}) begin
      n_err++;
      $display("FAIL reset_rr: got ss=%b rd=%b wr=%b mk=%b busy=%b", ss1, rd1, wr1, mk1, busy1);
    end
    n_vec++;
    if ({ss2, rd2, wr2, addr2, mk2, busy2} !== {8'b0, 1'b0, 1'b0, 23'h0, 2'b11, 1'b0}) begin
      n_err++;
      $display("FAIL reset_wide: got ss=%b rd=%b addr=%h mk=%b", ss2, rd2, addr2, mk2);
    end
  endtask

  task automatic test_fixed_priority();
    logic [21:0] a[5];
    for (int i = 0; i < 5; i++) begin
      a[i] = 22'($urandom);
      req_addr[i*22 +: 22] = a[i];
    end
    req_rnw = '1;
    req = 5'b10100;
    tick();
    n_vec++;
    if ({ss0, rd0, wr0, addr0, busy0} !== {5'b00100, 1'b1, 1'b0, a[2], 1'b1}) begin
      n_err++;
      $display("FAIL fixed_first: got ss=%b rd=%b wr=%b addr=%h busy=%b, want ss=00100 rd=1 wr=0 addr=%h busy=1",
               ss0, rd0, wr0, addr0, busy0, a[2]);
    end
    sdram_ack = 1;
    tick();
    sdram_ack = 0;
    n_vec++;
    if ({ss0, rd0} !== {5'b00100, 1'b0}) begin
      n_err++;
      $display("FAIL fixed_ack: got ss=%b rd=%b, want ss=00100 rd=0", ss0, rd0);
    end
    data_rdy = 1;
    tick();
    data_rdy = 0;
    n_vec++;
    if ({ss0, rd0, addr0} !== {5'b10000, 1'b1, a[4]}) begin
      n_err++;
      $display("FAIL fixed_next: got ss=%b rd=%b addr=%h, want ss=10000 rd=1 addr=%h", ss0, rd0, addr0, a[4]);
    end
    req = '0;
    data_rdy = 1;
    tick();
    data_rdy = 0;
    n_vec++;
    if ({ss0, rd0, wr0, busy0} !== {5'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL fixed_release: got ss=%b rd=%b wr=%b busy=%b, want idle", ss0, rd0, wr0, busy0);
    end
  endtask

  task automatic test_round_robin();
    int order[6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    req = 5'b00111;
    tick();
    for (int g = 0; g < 6; g++) begin
      if (g > 0) begin
        sdram_ack = 1;
        tick();
        sdram_ack = 0;
        tick();
        tick();
        data_rdy = 1;
        tick();
        data_rdy = 0;
      end
      n_vec++;
      if (ss1 !== 5'(1 << order[g])) begin
        n_err++;
        $display("FAIL rr_order[%0d]: got ss=%b, want slot %0d", g, ss1, order[g]);
      end
    end
  endtask

  task automatic test_writes();
    do_reset();
    req_rnw[1] = 0;
    req_din[16 +: 16] = 16'hA55A;
    req_wrmask[2 +: 2] = 2'b01;
    req = 5'b00010;
    tick();
    n_vec++;
    if ({ss0, wr0, rd0, dw0, mk0} !== {5'b00010, 1'b1, 1'b0, 16'hA55A, 2'b01}) begin
      n_err++;
      $display("FAIL write_slot1: got ss=%b wr=%b rd=%b dw=%h mk=%b, want wr=1 rd=0 dw=a55a mk=01",
               ss0, wr0, rd0, dw0, mk0);
    end
    req = '0;
    data_rdy = 1;
    tick();
    data_rdy = 0;
    req_rnw[3] = 0;
    req_din[48 +: 16] = 16'h1234;
    req_wrmask[6 +: 2] = 2'b10;
    req = 5'b01000;
    tick();
    n_vec++;
    if ({ss0, rd0, wr0, mk0, dw0} !== {5'b01000, 1'b1, 1'b0, 2'b11, 16'hA55A}) begin
      n_err++;
      $display("FAIL write_noperm: got ss=%b rd=%b wr=%b mk=%b dw=%h, want rd=1 wr=0 mk=11 dw=a55a",
               ss0, rd0, wr0, mk0, dw0);
    end
  endtask

  task automatic test_strobe_handshake();
    do_reset();
    req = 5'b00001;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (rd0 !== 1'b1) begin
        n_err++;
        $display("FAIL strobe_hold[%0d]: got rd=%b, want 1", k, rd0);
      end
      if (k < 2) tick();
    end
    sdram_ack = 1;
    tick();
    sdram_ack = 0;
    n_vec++;
    if (rd0 !== 1'b0) begin
      n_err++;
      $display("FAIL strobe_drop: got rd=%b, want 0", rd0);
    end
    req = 5'b00011;
    sdram_ack = 1;
    data_rdy = 1;
    tick();
    sdram_ack = 0;
    data_rdy = 0;
    n_vec++;
    if ({ss0, rd0} !== {5'b00010, 1'b1}) begin
      n_err++;
      $display("FAIL strobe_coincide: got ss=%b rd=%b, want ss=00010 rd=1", ss0, rd0);
    end
    tick();
    n_vec++;
    if (rd0 !== 1'b1) begin
      n_err++;
      $display("FAIL strobe_coincide_hold: got rd=%b, want 1", rd0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_addr[88 +: 22] = 22'h2ABCDE;
    req = 5'b10000;
    tick();
    n_vec++;
    if ({ss0, rd0, addr0} !== {5'b10000, 1'b1, 22'h2ABCDE}) begin
      n_err++;
      $display("FAIL mid_grant: got ss=%b rd=%b addr=%h", ss0, rd0, addr0);
    end
    rst = 1;
    req = '0;
    tick();
    rst = 0;
    n_vec++;
    if ({ss0, rd0, wr0, addr0, dw0, mk0, busy0} !== {5'b0, 1'b0, 1'b0, 22'h0, 16'h0, 2'b11, 1'b0}) begin
      n_err++;
      $display("FAIL mid_reset: got ss=%b rd=%b wr=%b addr=%h dw=%h mk=%b busy=%b",
               ss0, rd0, wr0, addr0, dw0, mk0, busy0);
    end
    data_rdy = 1;
    tick();
    data_rdy = 0;
    n_vec++;
    if ({ss0, rd0, busy0} !== {5'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL mid_stray_rdy: got ss=%b rd=%b busy=%b, want idle", ss0, rd0, busy0);
    end
  endtask

  task automatic test_wide();
    addr8_in[7*23 +: 23] = 23'h7FFFFF;
    addr8_in[6*23 +: 23] = 23'h012345;
    req8 = 8'h80;
    tick();
    n_vec++;
    if ({ss2, rd2, addr2} !== {8'h80, 1'b1, 23'h7FFFFF}) begin
      n_err++;
      $display("FAIL wide_slot7: got ss=%b rd=%b addr=%h, want ss=80 rd=1 addr=7fffff", ss2, rd2, addr2);
    end
    req8 = 8'hC0;
    rdy8 = 1;
    tick();
    rdy8 = 0;
    n_vec++;
    if ({ss2, addr2} !== {8'h40, 23'h012345}) begin
      n_err++;
      $display("FAIL wide_slot6: got ss=%b addr=%h, want ss=40 addr=012345", ss2, addr2);
    end
    req8 = '0;
  endtask

  task automatic test_random();
    logic [4:0] es;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      req        = 5'($urandom);
      req_rnw    = 5'($urandom);
      for (int i = 0; i < 5; i++) begin
        req_addr[i*22 +: 22] = 22'($urandom);
        req_din[i*16 +: 16]  = 16'($urandom);
      end
      req_wrmask = 10'($urandom);
      sdram_ack  = ($urandom_range(0, 3) == 0);
      data_rdy   = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      tick();
      for (int c = 0; c < 2; c++) begin
        es = (m_cur[c] < 0) ? 5'd0 : 5'(1 << m_cur[c]);
        n_vec++;
        if (c == 0 && {ss0, rd0, wr0, addr0, dw0, mk0, busy0} !==
            {es, m_rd[0], m_wr[0], m_addr[0], m_dw[0], m_mk[0], es != 0}) begin
          n_err++;
          $display("FAIL rand_fixed @%0d: got ss=%b rd=%b wr=%b addr=%h dw=%h mk=%b, want ss=%b rd=%b wr=%b addr=%h dw=%h mk=%b",
                   n, ss0, rd0, wr0, addr0, dw0, mk0, es, m_rd[0], m_wr[0], m_addr[0], m_dw[0], m_mk[0]);
        end
        if (c == 1 && {ss1, rd1, wr1, addr1, dw1, mk1, busy1} !==
            {es, m_rd[1], m_wr[1], m_addr[1], m_dw[1], m_mk[1], es != 0}) begin
          n_err++;
          $display("FAIL rand_rr @%0d: got ss=%b rd=%b wr=%b addr=%h dw=%h mk=%b, want ss=%b rd=%b wr=%b addr=%h dw=%h mk=%b",
                   n, ss1, rd1, wr1, addr1, dw1, mk1, es, m_rd[1], m_wr[1], m_addr[1], m_dw[1], m_mk[1]);
        end
      end
    end
    rst = 0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_writes();
    test_strobe_handshake();
    test_reset_mid();
    test_wide();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
